// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module   : mux_rr_arbiter (with leaf module multiplexer)
// Purpose  : Round-robin arbiter sharing an 8:1 one-bit mux among 8 sources.
//            Optional macro MUX_ARB_LOCK_EN adds a lock input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplexer (
  input  logic [7:0] data,
  input  logic [2:0] sel,
  output logic       y
);
  assign y = data[sel];
endmodule

module mux_rr_arbiter #(
  parameter int N        = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     data,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] address,
  output logic             valid,
  output logic             data_out
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

  logic [0:0]       r_state;
  logic [N-1:0]     r_grant;
  logic [SEL_W-1:0] r_address;
  logic             r_valid;
  logic [SEL_W-1:0] r_ptr;
  logic [7:0]       r_hold;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic [N-1:0]     w_onehot;
  logic             w_owner_req;
  logic             w_others;
  logic             w_timeout;
  logic             w_lock;
  logic             w_mux_y;

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = lock & r_valid;
`else
  assign w_lock = 1'b0;
`endif

  // Rotating search: first requester at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[r_ptr + SEL_W'(k)]) begin
        w_found = 1'b1;
        w_idx   = r_ptr + SEL_W'(k);
      end
    end
  end

  assign w_onehot    = N'(1) << w_idx;
  assign w_owner_req = |(req & r_grant);
  assign w_others    = |(req & ~r_grant);
  assign w_timeout   = (r_hold == c_hold_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_address <= '0;
      r_valid   <= 1'b0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state   <= S_GRANT;
            r_grant   <= w_onehot;
            r_address <= w_idx;
            r_valid   <= 1'b1;
            r_ptr     <= w_idx + SEL_W'(1);
            r_hold    <= '0;
          end
        end
        S_GRANT: begin
          // Release outranks timeout; preemption needs a contender.
          if ((!w_owner_req && w_found) ||
              (w_owner_req && w_timeout && w_others && !w_lock)) begin
            r_grant   <= w_onehot;
            r_address <= w_idx;
            r_ptr     <= w_idx + SEL_W'(1);
            r_hold    <= '0;
          end else if (!w_owner_req) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_valid   <= 1'b0;
          end else if (!w_lock && !w_timeout) begin
            r_hold    <= r_hold + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  multiplexer u_mux (
    .data (data),
    .sel  (r_address),
    .y    (w_mux_y)
  );

  assign grant    = r_grant;
  assign address  = r_address;
  assign valid    = r_valid;
  assign data_out = w_mux_y & r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Purpose  : Scoreboard bench for mux_rr_arbiter with a rule-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data;
  logic [7:0] grant;
  logic [2:0] address;
  logic       valid;
  logic       data_out;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif

  mux_rr_arbiter #(.N(8), .SEL_W(3), .MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
`ifdef MUX_ARB_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .address  (address),
    .valid    (valid),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] a;
    logic       v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: owner index (-1 = none), rotating pointer, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_addr  = 0;

  function automatic int search(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic give(input int i);
    m_owner = i;
    m_addr  = i;
    m_ptr   = (i + 1) % 8;
    m_hold  = 0;
  endtask

  task automatic model_step();
    logic lk;
    logic [7:0] others;
    lk = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lk = lock;
`endif
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_addr = 0;
    end else if (m_owner < 0) begin
      if (req != 8'h00) give(search(req, m_ptr));
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        if (req != 8'h00) give(search(req, m_ptr));
        else m_owner = -1;
      end else if (m_hold == MAXH - 1 && others != 8'h00 && !lk) begin
        give(search(req, m_ptr));
      end else if (!lk && m_hold < MAXH - 1) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_step();
    e.g = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    e.a = 3'(m_addr);
    e.v = (m_owner >= 0);
    q.push_back(e);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    logic exp_do;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_do = e.v ? data[e.a] : 1'b0;
        chk("grant",    int'(grant),    int'(e.g));
        chk("address",  int'(address),  int'(e.a));
        chk("valid",    int'(valid),    int'(e.v));
        chk("data_out", int'(data_out), int'(exp_do));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 8'h00; data = 8'h00;
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    // Single requester 2, then release.
    req = 8'h04; data = 8'h04;
    repeat (4) step();
    req = 8'h00;
    repeat (3) step();
    // Everyone requesting: full rotation.
    req = 8'hFF;
    repeat (40) begin
      data = 8'($urandom);
      step();
    end
    req = 8'h00;
    repeat (2) step();
    // Solo owner 5 saturates, then requester 1 arrives.
    req = 8'h20;
    repeat (8) step();
    req = 8'h22;
    repeat (6) step();
    req = 8'h00;
    repeat (2) step();
    // Owner 3 releases on its timeout edge while 6 and 0 wait.
    req = 8'h08;
    repeat (6) step();
    req = 8'h41;
    repeat (2) step();
    req = 8'h01;
    repeat (3) step();
    req = 8'h00;
    repeat (2) step();
    // Reset during an active grant to 7.
    req = 8'h80;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b1; req = 8'h04;
    repeat (2) step();
    req = 8'hFF;
    repeat (8) step();
    lock = 1'b0;
    repeat (3) step();
`endif
    // Randomized level-held requests.
    repeat (500) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      data = 8'($urandom);
`ifdef MUX_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
